ahb_policy_firewall: RTL and testbench
======================================

Name: ahb_policy_firewall

Overview:
- Parametrised successor to the AHB-Lite transaction monitor. Sits between one AHB-Lite master and one slave port of the ahb_ic fabric.
- Enforces address-permission (APU) and write-data (DPU) policies per master ID. Blocked transfers are never forwarded and receive a two-cycle AHB ERROR response.
- New over the previous generation: width and policy-count generality, a per-policy enable bit, a violation log FIFO, and a saturating violation counter.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MID_W, 32, master ID width
- NUM_APU, 16, APU policy count (≥1)
- NUM_DPU, 16, DPU policy count (≥1)
- LOG_DEPTH, 4, violation log entries (power of 2, ≥2)
- CNT_W, 16, violation counter width
- LOCK_THRESH, 8, lockout threshold (used only with the optional feature)

Ports:
- hclk in 1: clock
- hresetn in 1: async active-low reset
- hsel_m, hwrite_m in 1; haddr_m in ADDR_W; hmaster_m in MID_W; hsize_m in 3; hwdata_m in DATA_W: master side
- hrdata_m out DATA_W; hready_m out 1; hresp_m out 1: master side
- hsel_s, hwrite_s out 1; haddr_s out ADDR_W; hmaster_s out MID_W; hsize_s out 3; hwdata_s out DATA_W: slave side
- hrdata_s in DATA_W; hready_s, hresp_s in 1: slave side
- apu_en in NUM_APU: per-policy enable
- apumid, apuaddr, apumask in NUM_APU×MID_W/ADDR_W/ADDR_W
- apuperm in NUM_APU×2: bit0 read, bit1 write
- dpu_en in NUM_DPU: per-policy enable
- dpumid, dpuaddr, dpuamask in NUM_DPU×MID_W/ADDR_W/ADDR_W
- dpudata, dpumask in NUM_DPU×DATA_W
- log_valid out 1; log_pop in 1
- log_type out 1: 0 = APU, 1 = DPU
- log_mid out MID_W; log_addr out ADDR_W
- log_ovf out 1: sticky; log_ovf_clr in 1
- viol_cnt out CNT_W

Behaviour:
- Reset values: hready_m=1, hresp_m=0, all slave outputs 0, log empty, log_valid=0, log_ovf=0, viol_cnt=0, FSM in PASS.
- Privileged master: hmaster_m < 2. Always passes APU and DPU checks and is never stalled.
- APU hit[i] requires all of:
  - apu_en[i] and apumid[i]==hmaster_m
  - (apuaddr&~apumask) ≤ haddr_m ≤ (apuaddr|apumask)
  - the perm bit matching hwrite_m is set
- APU violation: no hit on any policy for a non-privileged transfer.
- DPU match[i] requires all of: dpu_en[i], dpumid==captured mid, captured addr in range, (hwdata_m & ~dpumask[i]) == dpudata[i]. Any match is a violation.
- FSM states: PASS, DCHK, ERR1, ERR2.
- PASS:
  - Slave outputs follow master combinationally, gated by hready_m.
  - Accepted transfer (hsel_m & hready_m) with APU violation → ERR1. Slave sees hsel_s=0.
  - Accepted non-privileged write passing APU → capture addr/mid/size, go to DCHK. Slave sees hsel_s=0. No forwarding in this cycle.
- DCHK (1 cycle): hready_m=0. hwdata_m is compared against the DPU policies.
  - Clean → drive the captured address phase to the slave (hsel_s=1), return to PASS. The next cycle drives captured-registered hwdata on hwdata_s.
  - Violation → ERR1. Slave untouched.
- ERR1: hready_m=0, hresp_m=1. → ERR2.
- ERR2: hready_m=1, hresp_m=1. → PASS. A new address phase in ERR2 is ignored (per AHB, the master cancels).
- Forwarded transfers: hready_m=hready_s, hresp_m=hresp_s, hrdata_m=hrdata_s, zero added latency. Slave wait states pass through, so a DCHK write costs exactly +1 cycle.
- Violation log:
  - Each violation pushes {type, mid, addr} on entering ERR1.
  - Head is presented on log_*. log_pop with log_valid pops.
  - Push and pop in the same cycle when full: both succeed.
  - Push when full without pop: entry dropped, log_ovf=1 until log_ovf_clr. Simultaneous set and clear: set wins.
- viol_cnt: +1 per violation, saturates at all-ones.
- hresetn assertion mid-transfer: immediate return to reset values. A pending DCHK transfer is discarded and never forwarded.

Optional Feature:
- Macro: AHB_FW_LOCKOUT_EN.
- When defined: once viol_cnt ≥ LOCK_THRESH, output lock=1 (extra port). Every non-privileged transfer then takes the APU-violation path (ERR1, logged, counted). lock_clr in 1 clears viol_cnt and lock.
- When undefined: no lock/lock_clr ports, no lockout.

Test Plan:
- mid=5, read 0x1000; policy0 {mid 5, addr 0x1000, mask 0xFF, perm 01} → forwarded same cycle, hresp_m=0, hrdata_m=hrdata_s.
- Same master writes 0x1010 with perm=01 → hsel_s stays 0; hready_m/hresp_m = 0/1 then 1/1. Log entry {0,5,0x1010}; viol_cnt=1.
- mid=5 writes 0xDEAD to 0x1004 with perm=11; DPU0 {mid 5, addr 0x1000, amask 0xF, data 0xDEAD, mask 0} → DCHK stall, then ERR. Log type=1; slave never selected.
- Same write with data 0xBEEF → 1 stall cycle, then slave sees addr 0x1004 and next cycle hwdata_s=0xBEEF.
- mid=1, any address, no policies enabled → forwarded with no stall and no log.
- 6 violations with LOG_DEPTH=4 and no pops → log_valid=1, 4 entries, log_ovf=1. Pop 4 → log_valid=0. log_ovf_clr → log_ovf=0.

Source files
------------

// File: rtl/ahb_policy_firewall.sv
// AHB-Lite policy firewall: APU address/permission and DPU write-data checks per master ID,
// violation log FIFO and saturating counter. Optional lockout enabled by AHB_FW_LOCKOUT_EN.
module ahb_policy_firewall #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MID_W       = 32,
  parameter int NUM_APU     = 16,
  parameter int NUM_DPU     = 16,
  parameter int LOG_DEPTH   = 4,
  parameter int CNT_W       = 16,
  parameter int LOCK_THRESH = 8
) (
  input  logic                       hclk,
  input  logic                       hresetn,
  input  logic                       hsel_m,
  input  logic                       hwrite_m,
  input  logic [ADDR_W-1:0]          haddr_m,
  input  logic [MID_W-1:0]           hmaster_m,
  input  logic [2:0]                 hsize_m,
  input  logic [DATA_W-1:0]          hwdata_m,
  output logic [DATA_W-1:0]          hrdata_m,
  output logic                       hready_m,
  output logic                       hresp_m,
  output logic                       hsel_s,
  output logic                       hwrite_s,
  output logic [ADDR_W-1:0]          haddr_s,
  output logic [MID_W-1:0]           hmaster_s,
  output logic [2:0]                 hsize_s,
  output logic [DATA_W-1:0]          hwdata_s,
  input  logic [DATA_W-1:0]          hrdata_s,
  input  logic                       hready_s,
  input  logic                       hresp_s,
  input  logic [NUM_APU-1:0]         apu_en,
  input  logic [NUM_APU*MID_W-1:0]   apumid,
  input  logic [NUM_APU*ADDR_W-1:0]  apuaddr,
  input  logic [NUM_APU*ADDR_W-1:0]  apumask,
  input  logic [NUM_APU*2-1:0]       apuperm,
  input  logic [NUM_DPU-1:0]         dpu_en,
  input  logic [NUM_DPU*MID_W-1:0]   dpumid,
  input  logic [NUM_DPU*ADDR_W-1:0]  dpuaddr,
  input  logic [NUM_DPU*ADDR_W-1:0]  dpuamask,
  input  logic [NUM_DPU*DATA_W-1:0]  dpudata,
  input  logic [NUM_DPU*DATA_W-1:0]  dpumask,
  output logic                       log_valid,
  input  logic                       log_pop,
  output logic                       log_type,
  output logic [MID_W-1:0]           log_mid,
  output logic [ADDR_W-1:0]          log_addr,
  output logic                       log_ovf,
  input  logic                       log_ovf_clr,
`ifdef AHB_FW_LOCKOUT_EN
  output logic                       lock,
  input  logic                       lock_clr,
`endif
  output logic [CNT_W-1:0]           viol_cnt
);

  typedef enum logic [1:0] {PASS, DCHK, ERR1, ERR2} state_t;
  localparam int PTR_W = $clog2(LOG_DEPTH);

  state_t              state_q;
  logic [ADDR_W-1:0]   capAddr_q;
  logic [MID_W-1:0]    capMid_q;
  logic [2:0]          capSize_q;
  logic [DATA_W-1:0]   capData_q;
  logic                dphase_q, wrReg_q, logOvf_q;
  logic [PTR_W:0]      wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]    violCnt_q;
  logic                logType_q [LOG_DEPTH];
  logic [MID_W-1:0]    logMid_q  [LOG_DEPTH];
  logic [ADDR_W-1:0]   logAddr_q [LOG_DEPTH];

  logic [NUM_APU-1:0]  apuHit;
  logic [NUM_DPU-1:0]  dpuMatch;
  logic                priv, lockOut, apuViol, dpuViol, readyInt, accept, fwd;
  logic                push, pushType, pop, full, pushOk;
  logic [MID_W-1:0]    pushMid;
  logic [ADDR_W-1:0]   pushAddr;

  assign priv = (hmaster_m[MID_W-1:1] == '0);

`ifdef AHB_FW_LOCKOUT_EN
  assign lock    = (violCnt_q >= CNT_W'(LOCK_THRESH));
  assign lockOut = lock;
`else
  assign lockOut = 1'b0;
`endif

  always_comb begin
    apuHit = '0;
    for (int i = 0; i < NUM_APU; i++)
      apuHit[i] = apu_en[i]
        && (apumid[i*MID_W +: MID_W] == hmaster_m)
        && (haddr_m >= (apuaddr[i*ADDR_W +: ADDR_W] & ~apumask[i*ADDR_W +: ADDR_W]))
        && (haddr_m <= (apuaddr[i*ADDR_W +: ADDR_W] | apumask[i*ADDR_W +: ADDR_W]))
        && (hwrite_m ? apuperm[2*i+1] : apuperm[2*i]);
  end

  // DPU checks run in DCHK against the captured address phase and the live write data
  always_comb begin
    dpuMatch = '0;
    for (int i = 0; i < NUM_DPU; i++)
      dpuMatch[i] = dpu_en[i]
        && (dpumid[i*MID_W +: MID_W] == capMid_q)
        && (capAddr_q >= (dpuaddr[i*ADDR_W +: ADDR_W] & ~dpuamask[i*ADDR_W +: ADDR_W]))
        && (capAddr_q <= (dpuaddr[i*ADDR_W +: ADDR_W] | dpuamask[i*ADDR_W +: ADDR_W]))
        && ((hwdata_m & ~dpumask[i*DATA_W +: DATA_W]) == dpudata[i*DATA_W +: DATA_W]);
  end

  assign apuViol = ~priv & (~|apuHit | lockOut);
  assign dpuViol = |dpuMatch;

  always_comb begin
    readyInt = 1'b1;
    hresp_m  = 1'b0;
    case (state_q)
      PASS: if (dphase_q) begin
        readyInt = hready_s;
        hresp_m  = hresp_s;
      end
      DCHK: readyInt = 1'b0;
      ERR1: begin
        readyInt = 1'b0;
        hresp_m  = 1'b1;
      end
      ERR2: hresp_m = 1'b1;
      default: ;
    endcase
  end

  assign hready_m = readyInt;
  assign hrdata_m = hrdata_s;
  assign accept   = (state_q == PASS) & hsel_m & readyInt;
  assign fwd      = accept & ~apuViol & (priv | ~hwrite_m);

  always_comb begin
    hsel_s    = 1'b0;
    hwrite_s  = 1'b0;
    haddr_s   = '0;
    hmaster_s = '0;
    hsize_s   = '0;
    if (fwd) begin
      hsel_s    = 1'b1;
      hwrite_s  = hwrite_m;
      haddr_s   = haddr_m;
      hmaster_s = hmaster_m;
      hsize_s   = hsize_m;
    end else if (state_q == DCHK && !dpuViol) begin
      hsel_s    = 1'b1;
      hwrite_s  = 1'b1;
      haddr_s   = capAddr_q;
      hmaster_s = capMid_q;
      hsize_s   = capSize_q;
    end
  end

  assign hwdata_s = wrReg_q ? capData_q : (dphase_q ? hwdata_m : '0);

  always_comb begin
    push     = 1'b0;
    pushType = 1'b0;
    pushMid  = hmaster_m;
    pushAddr = haddr_m;
    if (accept && apuViol) begin
      push = 1'b1;
    end else if (state_q == DCHK && dpuViol) begin
      push     = 1'b1;
      pushType = 1'b1;
      pushMid  = capMid_q;
      pushAddr = capAddr_q;
    end
  end

  assign log_valid = (wrPtr_q != rdPtr_q);
  assign full      = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) && (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
  assign pop       = log_pop & log_valid;
  assign pushOk    = push & (~full | pop);
  assign log_type  = logType_q[rdPtr_q[PTR_W-1:0]];
  assign log_mid   = logMid_q[rdPtr_q[PTR_W-1:0]];
  assign log_addr  = logAddr_q[rdPtr_q[PTR_W-1:0]];
  assign log_ovf   = logOvf_q;
  assign viol_cnt  = violCnt_q;

  // dphase_q marks a forwarded data phase in flight; wrReg_q selects the captured DCHK write data
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= PASS;
      dphase_q  <= 1'b0;
      wrReg_q   <= 1'b0;
      capAddr_q <= '0;
      capMid_q  <= '0;
      capSize_q <= '0;
      capData_q <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      logOvf_q  <= 1'b0;
      violCnt_q <= '0;
    end else begin
      case (state_q)
        PASS: begin
          if (readyInt) begin
            dphase_q <= fwd;
            wrReg_q  <= 1'b0;
          end
          if (accept && apuViol)                state_q <= ERR1;
          else if (accept && !priv && hwrite_m) state_q <= DCHK;
        end
        DCHK: begin
          state_q   <= dpuViol ? ERR1 : PASS;
          dphase_q  <= ~dpuViol;
          wrReg_q   <= ~dpuViol;
          capData_q <= hwdata_m;
        end
        ERR1: begin
          state_q  <= ERR2;
          dphase_q <= 1'b0;
          wrReg_q  <= 1'b0;
        end
        default: begin
          state_q  <= PASS;
          dphase_q <= 1'b0;
          wrReg_q  <= 1'b0;
        end
      endcase
      if (accept) begin
        capAddr_q <= haddr_m;
        capMid_q  <= hmaster_m;
        capSize_q <= hsize_m;
      end
      if (pushOk) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)    rdPtr_q <= rdPtr_q + 1'b1;
      if (push && full && !pop) logOvf_q <= 1'b1;
      else if (log_ovf_clr)     logOvf_q <= 1'b0;
`ifdef AHB_FW_LOCKOUT_EN
      if (lock_clr) violCnt_q <= '0;
      else
`endif
      if (push && violCnt_q != '1) violCnt_q <= violCnt_q + 1'b1;
    end
  end

  always_ff @(posedge hclk) begin
    if (pushOk) begin
      logType_q[wrPtr_q[PTR_W-1:0]] <= pushType;
      logMid_q[wrPtr_q[PTR_W-1:0]]  <= pushMid;
      logAddr_q[wrPtr_q[PTR_W-1:0]] <= pushAddr;
    end
  end

endmodule

// File: tb/tb_ahb_policy_firewall.sv
// Self-checking bench for ahb_policy_firewall: directed scenarios plus randomized transfers
// checked against a transaction-level policy model and a queue model of the violation log.
module tb_ahb_policy_firewall;
  localparam int NA = 16, ND = 16, DEPTH = 4;
  localparam int O_FWD = 0, O_APU = 1, O_OK = 2, O_DPU = 3;

  logic hclk = 1'b0;
  logic hresetn;
  always #5 hclk = ~hclk;

  logic hsel_m, hwrite_m, hready_m, hresp_m, hsel_s, hwrite_s, hready_s, hresp_s;
  logic [31:0] haddr_m, hmaster_m, hwdata_m, hrdata_m, haddr_s, hmaster_s, hwdata_s, hrdata_s;
  logic [2:0] hsize_m, hsize_s;
  logic [NA-1:0] apu_en;
  logic [NA*32-1:0] apumid, apuaddr, apumask;
  logic [NA*2-1:0] apuperm;
  logic [ND-1:0] dpu_en;
  logic [ND*32-1:0] dpumid, dpuaddr, dpuamask, dpudata, dpumask;
  logic log_valid, log_pop, log_type, log_ovf, log_ovf_clr;
  logic [31:0] log_mid, log_addr;
  logic [15:0] viol_cnt;
`ifdef AHB_FW_LOCKOUT_EN
  logic lock, lockClr;
`endif

  ahb_policy_firewall #(.LOG_DEPTH(DEPTH)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .hsel_m(hsel_m), .hwrite_m(hwrite_m), .haddr_m(haddr_m), .hmaster_m(hmaster_m),
    .hsize_m(hsize_m), .hwdata_m(hwdata_m), .hrdata_m(hrdata_m), .hready_m(hready_m),
    .hresp_m(hresp_m), .hsel_s(hsel_s), .hwrite_s(hwrite_s), .haddr_s(haddr_s),
    .hmaster_s(hmaster_s), .hsize_s(hsize_s), .hwdata_s(hwdata_s), .hrdata_s(hrdata_s),
    .hready_s(hready_s), .hresp_s(hresp_s),
    .apu_en(apu_en), .apumid(apumid), .apuaddr(apuaddr), .apumask(apumask), .apuperm(apuperm),
    .dpu_en(dpu_en), .dpumid(dpumid), .dpuaddr(dpuaddr), .dpuamask(dpuamask),
    .dpudata(dpudata), .dpumask(dpumask),
    .log_valid(log_valid), .log_pop(log_pop), .log_type(log_type), .log_mid(log_mid),
    .log_addr(log_addr), .log_ovf(log_ovf), .log_ovf_clr(log_ovf_clr),
`ifdef AHB_FW_LOCKOUT_EN
    .lock(lock), .lock_clr(lockClr),
`endif
    .viol_cnt(viol_cnt)
  );

  // Policy tables kept as plain arrays and flattened onto the DUT ports
  logic [31:0] apMid [NA], apAddr [NA], apMask [NA];
  logic [1:0]  apPerm [NA];
  logic        apEn [NA];
  logic [31:0] dpMid [ND], dpAddr [ND], dpAmask [ND], dpData [ND], dpMask [ND];
  logic        dpEn [ND];

  always_comb begin
    apu_en = '0; apumid = '0; apuaddr = '0; apumask = '0; apuperm = '0;
    dpu_en = '0; dpumid = '0; dpuaddr = '0; dpuamask = '0; dpudata = '0; dpumask = '0;
    for (int i = 0; i < NA; i++) begin
      apu_en[i] = apEn[i];
      apumid[i*32 +: 32] = apMid[i];
      apuaddr[i*32 +: 32] = apAddr[i];
      apumask[i*32 +: 32] = apMask[i];
      apuperm[i*2 +: 2] = apPerm[i];
    end
    for (int i = 0; i < ND; i++) begin
      dpu_en[i] = dpEn[i];
      dpumid[i*32 +: 32] = dpMid[i];
      dpuaddr[i*32 +: 32] = dpAddr[i];
      dpuamask[i*32 +: 32] = dpAmask[i];
      dpudata[i*32 +: 32] = dpData[i];
      dpumask[i*32 +: 32] = dpMask[i];
    end
  end

  typedef struct { logic typ; logic [31:0] mid; logic [31:0] addr; } entry_t;
  entry_t logQ [$];
  logic mOvf;
  int mCnt;
  int passCnt = 0, totalCnt = 0;

  logic [14:0] obsTrace;
  logic [31:0] obsAddr, obsMid, obsWdata, obsRdata, obsRdExp;
  logic obsWr;
  int lastOutc;

  always @(posedge hclk) hrdata_s <= $urandom;

  function automatic int predict(logic [31:0] mid, logic [31:0] addr, logic wr, logic [31:0] data);
    bit hit = 0, bad = 0;
    if (mid < 2) return O_FWD;
    for (int i = 0; i < NA; i++)
      if (apEn[i] && apMid[i] == mid && addr >= (apAddr[i] & ~apMask[i]) &&
          addr <= (apAddr[i] | apMask[i]) && apPerm[i][wr]) hit = 1;
    if (!hit) return O_APU;
    if (!wr) return O_FWD;
    for (int i = 0; i < ND; i++)
      if (dpEn[i] && dpMid[i] == mid && addr >= (dpAddr[i] & ~dpAmask[i]) &&
          addr <= (dpAddr[i] | dpAmask[i]) && (data & ~dpMask[i]) == dpData[i]) bad = 1;
    return bad ? O_DPU : O_OK;
  endfunction

  // Per cycle {hready_m, hresp_m, hsel_s}, five cycles starting at the address phase
  function automatic logic [14:0] expTrace(int outc);
    case (outc)
      O_FWD:   return {3'b101, 3'b100, 3'b100, 3'b100, 3'b100};
      O_APU:   return {3'b100, 3'b010, 3'b110, 3'b100, 3'b100};
      O_OK:    return {3'b100, 3'b001, 3'b100, 3'b100, 3'b100};
      default: return {3'b100, 3'b000, 3'b010, 3'b110, 3'b100};
    endcase
  endfunction

  function automatic bit modelPush(logic typ, logic [31:0] mid, logic [31:0] addr);
    entry_t e;
    e.typ = typ; e.mid = mid; e.addr = addr;
    if (mCnt < 65535) mCnt++;
    if (logQ.size() < DEPTH) begin
      logQ.push_back(e);
      return 0;
    end
    mOvf = 1;
    return 1;
  endfunction

  task automatic clearPolicies;
    for (int i = 0; i < NA; i++) begin
      apEn[i] = 0; apMid[i] = 0; apAddr[i] = 0; apMask[i] = 0; apPerm[i] = 0;
    end
    for (int i = 0; i < ND; i++) begin
      dpEn[i] = 0; dpMid[i] = 0; dpAddr[i] = 0; dpAmask[i] = 0; dpData[i] = 0; dpMask[i] = 0;
    end
  endtask

  task automatic doXfer(input logic [31:0] mid, input logic [31:0] addr, input logic wr,
                        input logic [31:0] data, input logic popNow, input logic clrNow);
    bit sawSel = 0, setOvf = 0;
    lastOutc = predict(mid, addr, wr, data);
    obsTrace = '0; obsAddr = '0; obsMid = '0; obsWr = 0; obsWdata = '0;
    @(posedge hclk); #1;
    hsel_m = 1; hmaster_m = mid; haddr_m = addr; hwrite_m = wr; hsize_m = 3'd2;
    log_pop = popNow; log_ovf_clr = clrNow;
    for (int c = 0; c < 5; c++) begin
      @(negedge hclk);
      obsTrace[14-3*c -: 3] = {hready_m, hresp_m, hsel_s};
      if (c == 1) begin obsRdata = hrdata_m; obsRdExp = hrdata_s; end
      if (sawSel) begin obsWdata = hwdata_s; sawSel = 0; end
      if (hsel_s) begin obsAddr = haddr_s; obsMid = hmaster_s; obsWr = hwrite_s; sawSel = 1; end
      @(posedge hclk);
      if (c == 0) begin
        if (popNow && logQ.size() > 0) void'(logQ.pop_front());
        if (lastOutc == O_APU) setOvf = modelPush(1'b0, mid, addr);
        if (clrNow && !setOvf) mOvf = 0;
      end
      if (c == 1 && lastOutc == O_DPU) void'(modelPush(1'b1, mid, addr));
      #1;
      if (c == 0) begin
        hsel_m = 0; haddr_m = $urandom; hwrite_m = 1'($urandom); hmaster_m = $urandom;
        hwdata_m = data; log_pop = 0; log_ovf_clr = 0;
      end
    end
  endtask

  task automatic popLog;
    @(posedge hclk); #1 log_pop = 1;
    @(posedge hclk);
    if (logQ.size() > 0) void'(logQ.pop_front());
    #1 log_pop = 0;
  endtask

  task automatic clrOvf;
    @(posedge hclk); #1 log_ovf_clr = 1;
    @(posedge hclk);
    mOvf = 0;
    #1 log_ovf_clr = 0;
  endtask

  task automatic applyReset;
    hresetn = 0;
    repeat (3) @(posedge hclk);
    logQ.delete(); mOvf = 0; mCnt = 0;
    #1 hresetn = 1;
  endtask

  task automatic test_reset;
    hsel_m = 0; hwrite_m = 0; haddr_m = 0; hmaster_m = 0; hsize_m = 0; hwdata_m = 0;
    hready_s = 1; hresp_s = 0; log_pop = 0; log_ovf_clr = 0;
`ifdef AHB_FW_LOCKOUT_EN
    lockClr = 0;
`endif
    clearPolicies();
    applyReset();
    @(negedge hclk);
    totalCnt++;
    if ({hready_m, hresp_m, hsel_s, hwrite_s, log_valid, log_ovf} !== 6'b100000)
      $display("[TB] FAIL reset_flags got %b want %b", {hready_m, hresp_m, hsel_s, hwrite_s, log_valid, log_ovf}, 6'b100000);
    else passCnt++;
    totalCnt++;
    if (haddr_s !== 0 || hmaster_s !== 0 || hwdata_s !== 0 || hsize_s !== 0)
      $display("[TB] FAIL reset_slave got addr %h mid %h wdata %h size %h want zero", haddr_s, hmaster_s, hwdata_s, hsize_s);
    else passCnt++;
    totalCnt++;
    if (viol_cnt !== 0) $display("[TB] FAIL reset_cnt got %0d want 0", viol_cnt); else passCnt++;
  endtask

  task automatic test_directed;
    apEn[0] = 1; apMid[0] = 5; apAddr[0] = 32'h1000; apMask[0] = 32'hFF; apPerm[0] = 2'b01;
    doXfer(5, 32'h1000, 0, 0, 0, 0);
    totalCnt++;
    if (obsTrace !== expTrace(O_FWD) || obsAddr !== 32'h1000)
      $display("[TB] FAIL read_fwd got trace %b addr %h want %b 00001000", obsTrace, obsAddr, expTrace(O_FWD));
    else passCnt++;
    totalCnt++;
    if (obsRdata !== obsRdExp) $display("[TB] FAIL read_data got %h want %h", obsRdata, obsRdExp); else passCnt++;

    doXfer(5, 32'h1010, 1, 32'h1234, 0, 0);
    totalCnt++;
    if (obsTrace !== expTrace(O_APU)) $display("[TB] FAIL apu_deny got %b want %b", obsTrace, expTrace(O_APU));
    else passCnt++;
    totalCnt++;
    if ({log_valid, log_type, log_mid, log_addr, viol_cnt} !== {1'b1, 1'b0, 32'd5, 32'h1010, 16'd1})
      $display("[TB] FAIL apu_log got v%b t%b mid %h addr %h cnt %0d want v1 t0 mid 5 addr 1010 cnt 1",
               log_valid, log_type, log_mid, log_addr, viol_cnt);
    else passCnt++;
    popLog();

    apPerm[0] = 2'b11;
    dpEn[0] = 1; dpMid[0] = 5; dpAddr[0] = 32'h1000; dpAmask[0] = 32'hF; dpData[0] = 32'hDEAD; dpMask[0] = 0;
    doXfer(5, 32'h1004, 1, 32'hDEAD, 0, 0);
    totalCnt++;
    if (obsTrace !== expTrace(O_DPU)) $display("[TB] FAIL dpu_deny got %b want %b", obsTrace, expTrace(O_DPU));
    else passCnt++;
    totalCnt++;
    if ({log_valid, log_type, log_mid, log_addr, viol_cnt} !== {1'b1, 1'b1, 32'd5, 32'h1004, 16'd2})
      $display("[TB] FAIL dpu_log got v%b t%b mid %h addr %h cnt %0d want v1 t1 mid 5 addr 1004 cnt 2",
               log_valid, log_type, log_mid, log_addr, viol_cnt);
    else passCnt++;
    popLog();

    doXfer(5, 32'h1004, 1, 32'hBEEF, 0, 0);
    totalCnt++;
    if (obsTrace !== expTrace(O_OK) || obsAddr !== 32'h1004 || obsWr !== 1'b1 || obsMid !== 5)
      $display("[TB] FAIL dpu_clean got trace %b addr %h wr %b mid %h want %b 00001004 1 5",
               obsTrace, obsAddr, obsWr, obsMid, expTrace(O_OK));
    else passCnt++;
    totalCnt++;
    if (obsWdata !== 32'hBEEF || log_valid !== 0 || viol_cnt !== 2)
      $display("[TB] FAIL dpu_wdata got %h valid %b cnt %0d want beef 0 2", obsWdata, log_valid, viol_cnt);
    else passCnt++;

    clearPolicies();
    doXfer(1, 32'hABCD0000, 1, 32'h5555, 0, 0);
    totalCnt++;
    if (obsTrace !== expTrace(O_FWD) || obsWdata !== 32'h5555 || log_valid !== 0 || viol_cnt !== 2)
      $display("[TB] FAIL priv_write got trace %b wdata %h valid %b cnt %0d want %b 5555 0 2",
               obsTrace, obsWdata, log_valid, viol_cnt, expTrace(O_FWD));
    else passCnt++;
  endtask

  task automatic test_back_to_back;
    @(posedge hclk); #1;
    for (int k = 0; k < 4; k++) begin
      hsel_m = 1; hmaster_m = 0; hwrite_m = 0; haddr_m = 32'h100 + 4*k;
      @(negedge hclk);
      totalCnt++;
      if (hsel_s !== 1 || haddr_s !== 32'h100 + 4*k || hready_m !== 1)
        $display("[TB] FAIL b2b_%0d got sel %b addr %h rdy %b want 1 %h 1", k, hsel_s, haddr_s, hready_m, 32'h100 + 4*k);
      else passCnt++;
      @(posedge hclk); #1;
    end
    hsel_m = 0; hready_s = 0; hresp_s = 0;
    @(negedge hclk);
    totalCnt++;
    if (hready_m !== 0 || hresp_m !== 0) $display("[TB] FAIL wait_state got rdy %b resp %b want 0 0", hready_m, hresp_m);
    else passCnt++;
    @(posedge hclk); #1 hready_s = 1;
    @(negedge hclk);
    totalCnt++;
    if (hready_m !== 1) $display("[TB] FAIL wait_release got rdy %b want 1", hready_m); else passCnt++;
  endtask

  task automatic test_log_overflow;
    clearPolicies();
    for (int k = 0; k < 6; k++) doXfer(7, 32'h2000 + 16*k, 1'(k % 2), 0, 0, 0);
    totalCnt++;
    if ({log_valid, log_ovf, log_addr, viol_cnt} !== {1'b1, 1'b1, 32'h2000, 16'd8})
      $display("[TB] FAIL ovf_full got v%b ovf%b addr %h cnt %0d want v1 ovf1 2000 8", log_valid, log_ovf, log_addr, viol_cnt);
    else passCnt++;
    for (int k = 0; k < 4; k++) begin
      totalCnt++;
      if (log_valid !== 1 || log_addr !== 32'h2000 + 16*k || log_mid !== 7)
        $display("[TB] FAIL ovf_head_%0d got v%b addr %h mid %h want 1 %h 7", k, log_valid, log_addr, log_mid, 32'h2000 + 16*k);
      else passCnt++;
      popLog();
    end
    totalCnt++;
    if (log_valid !== 0 || log_ovf !== 1) $display("[TB] FAIL ovf_drained got v%b ovf%b want 0 1", log_valid, log_ovf);
    else passCnt++;
    clrOvf();
    totalCnt++;
    if (log_ovf !== 0) $display("[TB] FAIL ovf_clr got %b want 0", log_ovf); else passCnt++;

    for (int k = 0; k < 4; k++) doXfer(9, 32'h3000 + 16*k, 0, 0, 0, 0);
    doXfer(9, 32'h3040, 0, 0, 1, 0);
    totalCnt++;
    if (log_ovf !== 0 || log_addr !== 32'h3010) $display("[TB] FAIL push_pop_full got ovf%b addr %h want 0 3010", log_ovf, log_addr);
    else passCnt++;
    doXfer(9, 32'h3050, 0, 0, 0, 1);
    totalCnt++;
    if (log_ovf !== 1) $display("[TB] FAIL ovf_set_wins got %b want 1", log_ovf); else passCnt++;
    while (logQ.size() > 0) popLog();
    clrOvf();
  endtask

  task automatic test_random;
    logic [31:0] mid, addr, data;
    logic wr;
    for (int n = 0; n < 150; n++) begin
      if (n % 25 == 0) begin
        for (int i = 0; i < NA; i++) begin
          apEn[i] = 1'($urandom); apMid[i] = 2 + $urandom % 4; apAddr[i] = $urandom % 256;
          apMask[i] = (32'h10 << ($urandom % 3)) - 1; apPerm[i] = 2'($urandom);
        end
        for (int i = 0; i < ND; i++) begin
          dpEn[i] = ($urandom % 3 == 0); dpMid[i] = 2 + $urandom % 4; dpAddr[i] = $urandom % 256;
          dpAmask[i] = 32'h3F; dpData[i] = $urandom % 4; dpMask[i] = 32'hFFFF_FFFC;
        end
      end
      mid = $urandom % 6; addr = $urandom % 256; wr = 1'($urandom); data = $urandom;
      doXfer(mid, addr, wr, data, ($urandom % 3 == 0), ($urandom % 8 == 0));
      totalCnt++;
      if (obsTrace !== expTrace(lastOutc))
        $display("[TB] FAIL rnd_trace_%0d got %b want %b (mid %0d addr %h wr %b)", n, obsTrace, expTrace(lastOutc), mid, addr, wr);
      else passCnt++;
      if (lastOutc == O_FWD || lastOutc == O_OK) begin
        totalCnt++;
        if (obsAddr !== addr || obsWr !== wr || obsMid !== mid || (wr && obsWdata !== data))
          $display("[TB] FAIL rnd_fwd_%0d got addr %h wr %b mid %h wdata %h want %h %b %h %h",
                   n, obsAddr, obsWr, obsMid, obsWdata, addr, wr, mid, data);
        else passCnt++;
      end
      totalCnt++;
      if (log_valid !== (logQ.size() > 0) || log_ovf !== mOvf || viol_cnt !== 16'(mCnt))
        $display("[TB] FAIL rnd_log_%0d got v%b ovf%b cnt %0d want v%b ovf%b cnt %0d",
                 n, log_valid, log_ovf, viol_cnt, (logQ.size() > 0), mOvf, mCnt);
      else passCnt++;
      if (logQ.size() > 0) begin
        totalCnt++;
        if (log_type !== logQ[0].typ || log_mid !== logQ[0].mid || log_addr !== logQ[0].addr)
          $display("[TB] FAIL rnd_head_%0d got t%b mid %h addr %h want t%b mid %h addr %h",
                   n, log_type, log_mid, log_addr, logQ[0].typ, logQ[0].mid, logQ[0].addr);
        else passCnt++;
      end
    end
  endtask

  task automatic test_reset_mid;
    clearPolicies();
    apEn[0] = 1; apMid[0] = 3; apAddr[0] = 0; apMask[0] = 32'hFFFF; apPerm[0] = 2'b11;
    doXfer(3, 32'h9000, 0, 0, 0, 0);
    @(posedge hclk); #1;
    hsel_m = 1; hmaster_m = 3; haddr_m = 32'h40; hwrite_m = 1;
    @(posedge hclk); #1;
    hsel_m = 0; hwdata_m = 32'h77;
    #1 hresetn = 0;
    #1;
    logQ.delete(); mOvf = 0; mCnt = 0;
    totalCnt++;
    if (hready_m !== 1 || hsel_s !== 0 || viol_cnt !== 0 || log_valid !== 0)
      $display("[TB] FAIL reset_mid got rdy %b sel %b cnt %0d v%b want 1 0 0 0", hready_m, hsel_s, viol_cnt, log_valid);
    else passCnt++;
    repeat (2) @(posedge hclk);
    #1 hresetn = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      totalCnt++;
      if (hsel_s !== 0 || hwdata_s !== 0) $display("[TB] FAIL reset_discard_%0d got sel %b wdata %h want 0 0", k, hsel_s, hwdata_s);
      else passCnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_log_overflow();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
